instr_encoder_li: RTL

- Sequential instruction encoder for the RISC-V CPU; the inverse of the U-type decoders.
- Takes a request (destination rd, 32-bit constant, absolute or PC-relative mode) and emits the 1–2 instruction words that materialise the constant: LUI/AUIPC, then ADDI.
- Feeds the boot-ROM builder and the self-test instruction generator over a valid/ready stream.

---
 rtl/instr_encoder_li_pkg.sv | 27 ++
 rtl/instr_encoder_li_split.sv | 44 ++++
 rtl/instr_encoder_li.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_encoder_li_pkg.sv
// Shared opcode constants, FSM state type and field-packing helpers for the
// load-immediate instruction encoder.
package instr_encoder_li_pkg;

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0]  F3_ADDI    = 3'b000;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } state_t;

  function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {hi, rd, opc};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] lo, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {lo, rs1, F3_ADDI, rd, OPC_OP_IMM};
  endfunction

endpackage

// File: rtl/instr_encoder_li_split.sv
// Combinational split of a 32-bit constant into upper/lower parts and selection
// of the one- or two-word sequence that materialises it.
module li_imm_split
  import instr_encoder_li_pkg::*;
(
  input  logic [31:0] imm,
  input  logic        pc_rel,
  input  logic [4:0]  rd,
  output logic [19:0] hi,
  output logic [11:0] lo,
  output logic [31:0] word1,
  output logic [31:0] word2,
  output logic        two_words
);

  // Rounding by 0x800 only ever carries into bit 12 when bit 11 is set, so the
  // upper part is the top 20 bits plus imm[11], wrapping at 2^20.
  assign hi = imm[31:12] + {19'd0, imm[11]};
  assign lo = imm[11:0];

  always_comb begin
    word1     = INSTR_NOP;
    word2     = INSTR_NOP;
    two_words = 1'b0;
    if (rd != 5'd0) begin
      if (pc_rel) begin
        word1 = enc_u(hi, rd, OPC_AUIPC);
        if (lo != 12'd0) begin
          word2     = enc_addi(lo, rd, rd);
          two_words = 1'b1;
        end
      end else if (hi == 20'd0) begin
        word1 = enc_addi(lo, 5'd0, rd);
      end else begin
        word1 = enc_u(hi, rd, OPC_LUI);
        if (lo != 12'd0) begin
          word2     = enc_addi(lo, rd, rd);
          two_words = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_encoder_li.sv
// Load-immediate encoder: accepts (rd, imm, mode) requests and streams out the
// LUI/AUIPC + ADDI words over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request
// EMIT1 | first word presented
// EMIT2 | second (final) word presented
module instr_encoder_li
  import instr_encoder_li_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_rd,
  input  logic [31:0]      req_imm,
  input  logic             req_pc_rel,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_last,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  state_t      state;
  logic [31:0] word2_q;
  logic [19:0] split_hi;
  logic [11:0] split_lo;
  logic [31:0] split_word1;
  logic [31:0] split_word2;
  logic        split_two;
  logic        unused_split;
  logic        hs;

  li_imm_split u_split (
    .imm       (req_imm),
    .pc_rel    (req_pc_rel),
    .rd        (req_rd),
    .hi        (split_hi),
    .lo        (split_lo),
    .word1     (split_word1),
    .word2     (split_word2),
    .two_words (split_two)
  );

  assign unused_split = ^{split_hi, split_lo};
  assign hs           = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_last  <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      word2_q     <= '0;
    end else begin
      if (hs) instr_count <= instr_count + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            instr       <= split_word1;
            instr_last  <= !split_two;
            word2_q     <= split_word2;
            instr_valid <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_EMIT1;
          end
        end
        ST_EMIT1: begin
          if (instr_ready) begin
            // instr_last already encodes the latched sequence length
            if (instr_last) begin
              instr_valid <= 1'b0;
              instr_last  <= 1'b0;
              req_ready   <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              instr      <= word2_q;
              instr_last <= 1'b1;
              state      <= ST_EMIT2;
            end
          end
        end
        ST_EMIT2: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            instr_last  <= 1'b0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          instr_valid <= 1'b0;
          instr_last  <= 1'b0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
